// File: rtl/matvec_sequencer_if.sv
// Handshake and array-side bundle for matvec_sequencer: load stream, result stream,
// systolic-array operand/result buses and status. slave = sequencer side, master = environment side.
interface matvec_sequencer_if #(
    parameter int MATRIX_SIZE = 16,
    parameter int DATA_W      = 8
);
    logic                                        in_valid;
    logic signed [DATA_W-1:0]                    in_data;
    logic                                        in_ready;
    logic                                        arr_reset;
    logic [MATRIX_SIZE*MATRIX_SIZE*DATA_W-1:0]   arr_a;
    logic [MATRIX_SIZE*DATA_W-1:0]               arr_b;
    logic [MATRIX_SIZE*DATA_W-1:0]               arr_c;
    logic                                        out_valid;
    logic signed [DATA_W-1:0]                    out_data;
    logic                                        out_last;
    logic                                        out_ready;
    logic                                        busy;
    logic                                        done;

    modport slave (
        input  in_valid, in_data, arr_c, out_ready,
        output in_ready, arr_reset, arr_a, arr_b, out_valid, out_data, out_last, busy, done
    );

    modport master (
        output in_valid, in_data, arr_c, out_ready,
        input  in_ready, arr_reset, arr_a, arr_b, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/matvec_sequencer.sv
// Streams an NxN matrix and N-vector into a systolic array, waits its latency, streams C back.
// Optional MATVEC_PERF_CNT_EN adds a saturating 32-bit busy-cycle counter output perf_cycles.
module matvec_sequencer #(
    parameter int MATRIX_SIZE   = 16,
    parameter int DATA_W        = 8,
    parameter int ARRAY_LATENCY = 20
) (
    input  logic              clk,
    input  logic              reset,
    matvec_sequencer_if.slave bus
`ifdef MATVEC_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);
    localparam int N     = MATRIX_SIZE;
    localparam int NN    = N * N;
    localparam int CNT_W = ($clog2(NN) > 8) ? $clog2(NN) : 8;
    localparam logic [CNT_W-1:0] LAST_A = CNT_W'(NN - 1);
    localparam logic [CNT_W-1:0] LAST_B = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(ARRAY_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, KICK, WAIT, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NN*DATA_W-1:0]     a_q, a_d;
    logic [N*DATA_W-1:0]      b_q, b_d;
    logic [N*DATA_W-1:0]      c_q, c_d;
    logic                     in_ready_q, in_ready_d;
    logic                     arr_reset_q, arr_reset_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = LOAD_A;
            LOAD_A: if (bus.in_valid && in_ready_q) begin
                a_d[32'(cnt_q)*DATA_W +: DATA_W] = bus.in_data;
                if (cnt_q == LAST_A) begin
                    cnt_d   = '0;
                    state_d = LOAD_B;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD_B: if (bus.in_valid && in_ready_q) begin
                b_d[32'(cnt_q)*DATA_W +: DATA_W] = bus.in_data;
                if (cnt_q == LAST_B) begin
                    cnt_d   = '0;
                    state_d = KICK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            KICK: state_d = WAIT;
            WAIT: begin
                if (cnt_q == LAST_W) begin
                    cnt_d   = '0;
                    c_d     = bus.arr_c;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: if (bus.out_ready) begin
                if (cnt_q == LAST_B) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet aligned with it.
        in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
        arr_reset_d = (state_d == IDLE) || (state_d == KICK);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DRAIN);
        out_last_d  = out_valid_d && (cnt_d == LAST_B);
        done_d      = out_last_d;
        out_data_d  = out_valid_d ? c_d[32'(cnt_d)*DATA_W +: DATA_W] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            in_ready_q  <= 1'b0;
            arr_reset_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            in_ready_q  <= in_ready_d;
            arr_reset_q <= arr_reset_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.arr_reset = arr_reset_q;
    assign bus.arr_a     = a_q;
    assign bus.arr_b     = b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

`ifdef MATVEC_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // The IDLE cycle that sees the first in_valid is counted as part of the operation.
    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (state_d == LOAD_A) perf_d = 32'd1;
        end else if (perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif
endmodule
